fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the combinational instruction ROM. It owns the program counter, drives the ROM address every cycle, and buffers fetched 16-bit instructions in a small queue toward decode with a valid/ready handshake. It also handles branch redirects (flush plus new PC) and halt/resume requests. It sits between the instruction ROM and the decode stage of the core.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch controller
// and its queue.
//   fetch_state_t : fetch FSM states (FAULT is only entered in a build with
//                   FETCH_BOUNDS_EN defined)
//   addr_t        : 16-bit byte address
//   instr_t       : 16-bit instruction word
//   fetch_entry_t : one queue entry, instruction plus the address it came from
//   PC_STEP       : byte distance between sequential fetches
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] instr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

  localparam addr_t PC_STEP = 16'd4;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched {instruction, pc} entries feeding
// decode. Flush empties the queue and wins over a same-cycle push or pop.
// The head entry is read straight from registered storage.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : discard all entries
//   push         : write push_data at the tail (caller guarantees room)
//   push_data    : entry to write
//   pop          : drop the head entry (caller guarantees not empty)
//   count        : number of valid entries
//   head         : oldest entry (all zeros out of reset)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output logic [$clog2(QDEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t  mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap explicitly so QDEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset because the head is driven straight from it;
      // this keeps inst_data/inst_pc at zero out of reset.
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller. Owns the PC, addresses the
// combinational instruction ROM every cycle and queues fetched instructions
// toward decode with a valid/ready handshake. Handles branch redirects
// (flush + new PC) and halt/resume.
// Optional feature: define FETCH_BOUNDS_EN to stop on fetches beyond the
// ROM (FAULT state, fault=1). Without it the PC wraps modulo MEM_SIZE and
// fault is tied low.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   imem_addr       : ROM byte address, always the current PC
//   imem_instr      : ROM read data for imem_addr (same cycle)
//   redirect_valid  : taken branch/jump; redirect_pc is the target
//   halt_req/resume : stop fetching / restart at the current PC
//   inst_valid/inst_data/inst_pc/inst_ready : queue head toward decode
//   fault           : registered out-of-bounds fetch flag
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int    MEM_SIZE = 1024,
  parameter int    QDEPTH   = 2,
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        inst_valid,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  output logic        fault
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_t  state, state_nxt;
  addr_t         pc, pc_nxt;
  addr_t         pc_seq;
  addr_t         redirect_target;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  logic          pop;
  logic          room;
  logic          enq;
  logic          in_bounds;

`ifdef FETCH_BOUNDS_EN
  localparam logic [16:0] MEM_LIMIT = 17'(MEM_SIZE);
  // Widened by one bit so PC+3 cannot wrap past the comparison.
  assign in_bounds = ({1'b0, pc} + 17'd3) < MEM_LIMIT;
  assign pc_seq    = pc + PC_STEP;
  assign fault     = (state == FAULT);
`else
  localparam addr_t ADDR_MASK = addr_t'(MEM_SIZE - 1);
  assign in_bounds = 1'b1;
  assign pc_seq    = (pc + PC_STEP) & ADDR_MASK;
  assign fault     = 1'b0;
`endif

  assign redirect_target = redirect_pc & 16'hFFFC;
  assign inst_valid      = (count != '0);
  assign pop             = inst_valid & inst_ready;
  // A same-cycle pop frees a slot, so a full queue can still accept.
  assign room            = (count < CW'(QDEPTH)) | pop;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    enq       = 1'b0;
    if (redirect_valid) begin
      pc_nxt = redirect_target;
      if (state != HALT) state_nxt = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (!in_bounds) begin
            state_nxt = FAULT;
          end else if (halt_req) begin
            state_nxt = HALT;
          end else if (room) begin
            enq    = 1'b1;
            pc_nxt = pc_seq;
          end
        end
        HALT:    if (resume && !halt_req) state_nxt = RUN;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Redirect flushes; the queue gives flush priority over a same-cycle pop.
  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (enq),
    .push_data ('{instr: imem_instr, pc: pc}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign imem_addr = pc;
  assign inst_data = head.instr;
  assign inst_pc   = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A queue-based reference
// model predicts each delivery to decode and pushes it to a scoreboard; a
// separate monitor pops and compares whenever decode accepts the DUT head.
// Directed scenarios are followed by randomized stimulus. Builds with or
// without FETCH_BOUNDS_EN.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int    MEM_SIZE = 1024;
  localparam int    QDEPTH   = 2;
  localparam addr_t RESET_PC = 16'h0000;
  localparam int    M_RUN = 0, M_HALT = 1, M_FAULT = 2;

  logic        clk;
  logic        reset_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        fault;

  fetch_ctrl #(.MEM_SIZE(MEM_SIZE), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word k (byte address 4k) holds 16'hA000 + k.
  function automatic instr_t rom(input addr_t a);
    return 16'hA000 + {2'b00, a[15:2]};
  endfunction

  assign imem_instr = rom(imem_addr);

  typedef struct {
    addr_t  pc;
    instr_t instr;
  } ent_t;

  int    tests = 0;
  int    fails = 0;
  ent_t  mq[$];     // model of the instruction queue
  ent_t  exp_q[$];  // scoreboard: deliveries decode should see, in order
  ent_t  mon_e;
  addr_t m_pc;
  int    m_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic addr_t next_pc(input addr_t p);
`ifdef FETCH_BOUNDS_EN
    return p + 16'd4;
`else
    return addr_t'((int'(p) + 4) % MEM_SIZE);
`endif
  endfunction

  function automatic bit oob(input addr_t p);
`ifdef FETCH_BOUNDS_EN
    return (int'(p) + 3) >= MEM_SIZE;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_pc = RESET_PC;
    m_st = M_RUN;
  endtask

  // One clock edge of the reference behaviour, given this cycle's inputs.
  task automatic model_step(input logic rv, input addr_t rpc, input logic hr,
                            input logic rs, input logic rdy);
    bit pop;
    pop = (mq.size() > 0) && rdy;
    if (rv) begin
      mq.delete();
      m_pc = rpc & 16'hFFFC;
      if (m_st == M_FAULT) m_st = M_RUN;
    end else begin
      if (pop) exp_q.push_back(mq.pop_front());
      case (m_st)
        M_RUN: begin
          if (oob(m_pc)) m_st = M_FAULT;
          else if (hr) m_st = M_HALT;
          else if (mq.size() < QDEPTH) begin
            mq.push_back('{pc: m_pc, instr: rom(m_pc)});
            m_pc = next_pc(m_pc);
          end
        end
        M_HALT: if (rs && !hr) m_st = M_RUN;
        default: ;
      endcase
    end
  endtask

  // Check state from the last edge, drive new inputs, advance the model.
  task automatic cycle(input logic rv, input addr_t rpc, input logic hr,
                       input logic rs, input logic rdy);
    @(negedge clk);
    check("imem_addr", imem_addr, m_pc);
    check("inst_valid", inst_valid, mq.size() > 0);
    check("fault", fault, m_st == M_FAULT);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    resume         = rs;
    inst_ready     = rdy;
    #1 model_step(rv, rpc, hr, rs, rdy);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, rdy);
  endtask

  // Observe the state just after the next rising edge.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    halt_req       = 1'b0;
    resume         = 1'b0;
    inst_ready     = rdy;
    #1;
    check("reset_async_valid", inst_valid, 1'b0);
    check("reset_async_addr", imem_addr, RESET_PC);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1 model_step(1'b0, 16'h0, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: whenever decode accepts the head, it must match the scoreboard.
  always @(negedge clk) begin
    #2;
    if (reset_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1 && redirect_valid === 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got pc %0h with no delivery expected at %0t", inst_pc, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", inst_pc, mon_e.pc);
        check("sb_data", inst_data, mon_e.instr);
      end
    end
  end

  logic  hr_lvl;
  logic  rv_r;
  addr_t rpc_r;

  initial begin
    reset_n        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    halt_req       = 1'b0;
    resume         = 1'b0;
    inst_ready     = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_data", inst_data, 16'h0);
    check("rst_inst_pc", inst_pc, 16'h0);
    check("rst_fault", fault, 1'b0);
    model_reset();

    // Streaming from reset with decode always ready.
    @(negedge clk);
    reset_n    = 1'b1;
    inst_ready = 1'b1;
    #1 model_step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    run(8, 1'b1);

    // Backpressure from reset: queue fills and the PC holds.
    do_reset(1'b0);
    run(5, 1'b0);
    settle();
    check("stall_addr", imem_addr, 4 * QDEPTH);
    check("stall_valid", inst_valid, 1'b1);
    check("stall_head_pc", inst_pc, 16'h0);
    run(4, 1'b1);

    // Redirect while full and popping.
    run(2, 1'b0);
    cycle(1'b1, 16'h0043, 1'b0, 1'b0, 1'b1);
    settle();
    check("redir_addr", imem_addr, 16'h0040);
    check("redir_flushed", inst_valid, 1'b0);
    run(1, 1'b1);
    settle();
    check("redir_head_valid", inst_valid, 1'b1);
    check("redir_head_pc", inst_pc, 16'h0040);
    check("redir_head_data", inst_data, 16'hA010);
    run(3, 1'b1);

    // Halt pulse, drain, then resume.
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    run(4, 1'b1);
    settle();
    check("halt_drained", inst_valid, 1'b0);
    check("halt_pc_hold", imem_addr, m_pc);
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    run(4, 1'b1);

    // Top-of-ROM behaviour.
    cycle(1'b1, 16'h03FC, 1'b0, 1'b0, 1'b1);
    run(1, 1'b1);
    settle();
`ifdef FETCH_BOUNDS_EN
    check("top_next_addr", imem_addr, 16'h0400);
`else
    check("top_next_addr", imem_addr, 16'h0000);
`endif
    run(1, 1'b1);
    settle();
`ifdef FETCH_BOUNDS_EN
    check("top_fault", fault, 1'b1);
`else
    check("top_fault", fault, 1'b0);
`endif
    run(2, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    settle();
    check("fault_cleared", fault, 1'b0);
    check("fault_exit_addr", imem_addr, 16'h0000);
    run(3, 1'b1);

    // Reset in the middle of a stream.
    run(3, 1'b1);
    do_reset(1'b1);
    run(3, 1'b1);

    // Randomized traffic.
    hr_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) hr_lvl = ~hr_lvl;
      rv_r  = !hr_lvl && ($urandom_range(0, 24) == 0);
      rpc_r = addr_t'($urandom_range(0, 65535)) & 16'h03FF;
      if ($urandom_range(0, 3) == 0) rpc_r = 16'h03F0 | addr_t'($urandom_range(0, 15));
      cycle(rv_r, rpc_r, hr_lvl, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    end
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    run(4, 1'b1);
    #5;
    check("sb_all_delivered", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
